// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
//
// IF-stage fetch sequencer. Owns the PC, drives a variable-latency instruction
// memory through a req/rdy handshake and produces the pcIn / instructionIn /
// freeze / flush controls for the IF/ID pipeline register.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   hazard        hazard-unit stall request (hold IF/ID)
//   branch_taken  branch resolved taken in EXE this cycle
//   branch_addr   branch target (bits [1:0] ignored)
//   imem_req      instruction memory request
//   imem_addr     instruction memory address
//   imem_rdy      memory returns data this cycle
//   imem_rdata    memory read data, valid with imem_rdy
//   if_pc         IF/ID pcIn, PC+4 of the delivered instruction
//   if_instr      IF/ID instructionIn
//   if_freeze     IF/ID freeze
//   if_flush      IF/ID flush
//   busy          fetch outstanding (state != S_HOLD)
//   perf_fetch_cnt / perf_stall_cnt  only with IF_FETCH_PERF_EN defined
//
// Build option
//   IF_FETCH_PERF_EN  adds saturating delivered-instruction and stall-cycle
//                     counters; functional behaviour is unchanged.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_REQ   | request at pc outstanding, deliver on rdy unless stalled
// S_HOLD  | word captured under hazard, waiting in instr_buf
// S_DRAIN | stale access at req_addr must complete, its data is discarded
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr,
    output logic              if_freeze,
    output logic              if_flush,
    output logic              busy
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] req_addr, req_addr_nxt;
    logic [31:0]       instr_buf, instr_buf_nxt;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_tgt;

    assign pc_inc = pc + ADDR_W'(4);
    assign br_tgt = {branch_addr[ADDR_W-1:2], 2'b00};
    assign busy   = (state != S_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            instr_buf <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            req_addr  <= req_addr_nxt;
            instr_buf <= instr_buf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        req_addr_nxt  = req_addr;
        instr_buf_nxt = instr_buf;
        imem_req      = 1'b0;
        imem_addr     = pc;
        if_freeze     = 1'b1;
        if_flush      = 1'b0;
        if_pc         = '0;
        if_instr      = '0;

        if (!rst) begin
            case (state)
                S_REQ: begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                    if (branch_taken) begin
                        if_flush = 1'b1;
                        pc_nxt   = br_tgt;
                        // A rdy in the same cycle completes the access, so
                        // nothing is left to drain.
                        if (!imem_rdy) begin
                            req_addr_nxt = pc;
                            state_nxt    = S_DRAIN;
                        end
                    end else if (imem_rdy && !hazard) begin
                        if_freeze = 1'b0;
                        if_pc     = pc_inc;
                        if_instr  = imem_rdata;
                        pc_nxt    = pc_inc;
                    end else if (imem_rdy) begin
                        instr_buf_nxt = imem_rdata;
                        state_nxt     = S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (branch_taken) begin
                        if_flush  = 1'b1;
                        pc_nxt    = br_tgt;
                        state_nxt = S_REQ;
                    end else if (!hazard) begin
                        if_freeze = 1'b0;
                        if_pc     = pc_inc;
                        if_instr  = instr_buf;
                        pc_nxt    = pc_inc;
                        state_nxt = S_REQ;
                    end
                end

                S_DRAIN: begin
                    // Memory cannot cancel, so keep presenting the stale
                    // address until it answers.
                    imem_req  = 1'b1;
                    imem_addr = req_addr;
                    if (branch_taken) begin
                        if_flush = 1'b1;
                        pc_nxt   = br_tgt;
                    end
                    if (imem_rdy) begin
                        state_nxt = S_REQ;
                    end
                end

                default: begin
                    state_nxt = S_REQ;
                end
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic fetch_evt;
    logic stall_evt;

    assign fetch_evt = !rst && !if_freeze;
    assign stall_evt = !rst && if_freeze && !if_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_evt && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall_evt && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_ctrl
//
// Directed-vector bench for if_fetch_ctrl (RESET_PC = 0). Inputs are applied
// 1 ns after each rising edge and the combinational outputs are sampled 2 ns
// later, well clear of both clock edges. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_freeze;
    logic        if_flush;
    logic        busy;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdy     (imem_rdy),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_freeze    (if_freeze),
        .if_flush     (if_flush),
        .busy         (busy)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs after the next rising edge, then settle.
    task automatic drive(input logic r, input logic h, input logic b,
                         input logic [31:0] ba, input logic y, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst          = r;
        hazard       = h;
        branch_taken = b;
        branch_addr  = ba;
        imem_rdy     = y;
        imem_rdata   = d;
        #2;
    endtask

    // Common output check: req, addr, freeze, flush, if_pc, if_instr.
    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic frz, input logic fl,
                           input logic [31:0] pc4, input logic [31:0] ins);
        chk({tag, ".req"},    32'(imem_req),  32'(req));
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".freeze"}, 32'(if_freeze), 32'(frz));
        chk({tag, ".flush"},  32'(if_flush),  32'(fl));
        chk({tag, ".if_pc"},  if_pc,          pc4);
        chk({tag, ".instr"},  if_instr,       ins);
    endtask

    initial begin
        // Reset held over two edges
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 32'h1111_1111);
        chk_out("rst", 0, 0, 1, 0, 0, 0);

        // Zero-wait memory: back-to-back fetch
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 32'hA000_0000 + 32'(i));
            chk_out("b2b", 1, 32'(4 * i), 0, 0, 32'(4 * i + 4), 32'hA000_0000 + 32'(i));
        end
        chk("b2b.busy", 32'(busy), 32'd1);

        // Two wait states per access, pc 16 then 20
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk_out("ws0", 1, 32'(16 + 4 * k), 1, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 0);
            chk_out("ws1", 1, 32'(16 + 4 * k), 1, 0, 0, 0);
            drive(0, 0, 0, 0, 1, 32'hE3A0_0001);
            chk_out("ws2", 1, 32'(16 + 4 * k), 0, 0, 32'(20 + 4 * k), 32'hE3A0_0001);
        end

        // Reset and advance to pc 8
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h0000_0100);
        chk_out("re0", 1, 32'h0, 0, 0, 32'h4, 32'h0000_0100);
        drive(0, 0, 0, 0, 1, 32'h0000_0104);
        chk_out("re4", 1, 32'h4, 0, 0, 32'h8, 32'h0000_0104);

        // rdy & hazard at pc 8: capture, hold 3 cycles, release
        drive(0, 1, 0, 0, 1, 32'hC0DE_0008);
        chk_out("hzcap", 1, 32'h8, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 32'hBAD0_0000);
            chk_out("hold", 0, 0, 1, 0, 0, 0);
            chk("hold.busy", 32'(busy), 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk_out("hzrel", 0, 0, 0, 0, 32'hC, 32'hC0DE_0008);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("hznext", 1, 32'hC, 1, 0, 0, 0);

        // Deliver 12, then wait on 16 and take branch to 0x43
        drive(0, 0, 0, 0, 1, 32'h0000_000C);
        chk_out("d12", 1, 32'hC, 0, 0, 32'h10, 32'h0000_000C);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("w16", 1, 32'h10, 1, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_0043, 0, 0);
        chk_out("br43", 1, 32'h10, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("drain", 1, 32'h10, 1, 0, 0, 0);
        chk("drain.busy", 32'(busy), 32'd1);
        drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk_out("drop", 1, 32'h10, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("at40", 1, 32'h40, 1, 0, 0, 0);

        // Branch, then a second branch during the drain
        drive(0, 0, 1, 32'h0000_0100, 0, 0);
        chk_out("brA", 1, 32'h40, 1, 1, 0, 0);
        drive(0, 0, 1, 32'h0000_0080, 0, 0);
        chk_out("brB", 1, 32'h40, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 32'hDEAD_0040);
        chk_out("drop2", 1, 32'h40, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h1234_5678);
        chk_out("at80", 1, 32'h80, 0, 0, 32'h84, 32'h1234_5678);

        // Branch coincident with rdy in S_REQ: data dropped, no drain
        drive(0, 0, 1, 32'h0000_0022, 1, 32'hDEAD_0084);
        chk_out("brrdy", 1, 32'h84, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("at20", 1, 32'h20, 1, 0, 0, 0);

        // Reset mid-wait at pc 0x20
        drive(1, 0, 0, 0, 0, 0);
        chk_out("rstmid", 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("postrst", 1, 32'h0, 1, 0, 0, 0);
`ifdef IF_FETCH_PERF_EN
        chk("perf.fetch0", perf_fetch_cnt, 32'd0);
        chk("perf.stall0", perf_stall_cnt, 32'd0);
`endif
        drive(0, 0, 0, 0, 0, 0);
        chk_out("pw1", 1, 32'h0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'hE3A0_0001);
        chk_out("pw2", 1, 32'h0, 0, 0, 32'h4, 32'hE3A0_0001);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("pw3", 1, 32'h4, 1, 0, 0, 0);
`ifdef IF_FETCH_PERF_EN
        chk("perf.fetch1", perf_fetch_cnt, 32'd1);
        chk("perf.stall2", perf_stall_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
